sram_uart_bridge: RTL

- Multi-cycle, registered bridge from the CPU MEM stage to the board's 32-bit SRAM and the 8-bit UART, which share the base-RAM data bus.
- One FSM with req/ack handshake and programmable wait states.
- Generates proper SRAM and UART strobes; no strobe is derived combinationally from clk.
- Address-mapped UART data/status registers; all other addresses go to SRAM.

---
 rtl/sram_uart_bridge_if.sv | 16 +
 rtl/sram_uart_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_uart_bridge_if.sv
// CPU-side request/acknowledge bus of the SRAM/UART bridge.
interface sram_uart_bridge_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        busy_o;

  modport master (output req_i, we_i, addr_i, sel_i, data_i,
                  input  data_o, ack_o, busy_o);
  modport slave  (input  req_i, we_i, addr_i, sel_i, data_i,
                  output data_o, ack_o, busy_o);
endinterface

// File: rtl/sram_uart_bridge.sv
// Registered multi-cycle bridge from the MEM stage to base SRAM and the UART on its low byte.
// Define UART_BLOCKING_EN to make UART data accesses wait for the device's status flags.
module sram_uart_bridge #(
  parameter int          ADDR_W         = 20,
  parameter int          WAIT_CYCLES    = 1,
  parameter int          UART_PULSE     = 2,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD003FC
) (
  input  logic              clk,
  input  logic              rst,
  sram_uart_bridge_if.slave bus,
  inout  wire  [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be_n,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  inout  wire  [7:0]        uart_data,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              tbre_i,
  input  logic              tsre_i,
  input  logic              data_ready_i
);

  localparam int CNT_MAX = (WAIT_CYCLES > UART_PULSE) ? WAIT_CYCLES : UART_PULSE;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] P_LAST = CW'(UART_PULSE - 1);

  typedef enum logic [3:0] {
    IDLE, SRD, SWS, SWP, SWH, URW, URD, UTW, UWR, UWH, DONE
  } state_t;

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [31:0]       data_reg;
  logic [31:0]       rdata_reg;
  logic              ack_reg;
  logic              busy_reg;
  logic              ram_drv_reg;
  logic              uart_drv_reg;

  assign ram_addr   = ram_addr_reg;
  assign bus.data_o = rdata_reg;
  assign bus.ack_o  = ack_reg;
  assign bus.busy_o = busy_reg;

  assign ram_data  = ram_drv_reg  ? data_reg      : {32{1'bz}};
  assign uart_data = uart_drv_reg ? data_reg[7:0] : {8{1'bz}};

  // Every strobe is a register updated on the transition into the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ram_addr_reg <= '0;
      data_reg     <= '0;
      rdata_reg    <= '0;
      ack_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      ram_drv_reg  <= 1'b0;
      uart_drv_reg <= 1'b0;
      ram_be_n     <= 4'hF;
      ram_ce_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      uart_rdn     <= 1'b1;
      uart_wrn     <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_i) begin
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
            ram_addr_reg <= bus.addr_i[ADDR_W+1:2];
            data_reg     <= bus.data_i;
            if (bus.addr_i == UART_STAT_ADDR) begin
              // Status writes are acknowledged but change nothing.
              if (!bus.we_i) rdata_reg <= {30'b0, data_ready_i, tbre_i & tsre_i};
              ack_reg   <= 1'b1;
              state_reg <= DONE;
            end else if (bus.addr_i == UART_DATA_ADDR) begin
              if (bus.we_i) begin
`ifdef UART_BLOCKING_EN
                state_reg    <= UTW;
`else
                state_reg    <= UWR;
                uart_wrn     <= 1'b0;
                uart_drv_reg <= 1'b1;
`endif
              end else begin
`ifdef UART_BLOCKING_EN
                state_reg <= URW;
`else
                state_reg <= URD;
                uart_rdn  <= 1'b0;
`endif
              end
            end else if (bus.we_i) begin
              state_reg   <= SWS;
              ram_ce_n    <= 1'b0;
              ram_be_n    <= ~bus.sel_i;
              ram_drv_reg <= 1'b1;
            end else begin
              state_reg <= SRD;
              ram_ce_n  <= 1'b0;
              ram_oe_n  <= 1'b0;
              ram_be_n  <= 4'h0;
            end
          end
        end
        SRD: begin
          if (cnt_reg == W_LAST) begin
            rdata_reg <= ram_data;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_be_n  <= 4'hF;
            ack_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SWS: begin
          ram_we_n  <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= SWP;
        end
        SWP: begin
          if (cnt_reg == W_LAST) begin
            ram_we_n  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= SWH;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        SWH: begin
          ram_ce_n    <= 1'b1;
          ram_be_n    <= 4'hF;
          ram_drv_reg <= 1'b0;
          ack_reg     <= 1'b1;
          state_reg   <= DONE;
        end
`ifdef UART_BLOCKING_EN
        URW: begin
          if (data_ready_i) begin
            uart_rdn  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= URD;
          end
        end
        UTW: begin
          if (tbre_i && tsre_i) begin
            uart_wrn     <= 1'b0;
            uart_drv_reg <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= UWR;
          end
        end
`endif
        URD: begin
          if (cnt_reg == P_LAST) begin
            rdata_reg <= {24'b0, uart_data};
            uart_rdn  <= 1'b1;
            ack_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        UWR: begin
          if (cnt_reg == P_LAST) begin
            uart_wrn  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= UWH;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        UWH: begin
          uart_drv_reg <= 1'b0;
          ack_reg      <= 1'b1;
          state_reg    <= DONE;
        end
        DONE: begin
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
